audiodac_upsampler: RTL and testbench
=====================================

# audiodac_upsampler

Linear-interpolating upsampler between the audio sample source (sine generator or sample FIFO) and the delta-sigma modulator. It paces the modulator with a programmable output strobe. Every 2**OSR_LOG2 output strobes it issues a one-cycle read to the source and captures that sample. Between captures it emits linearly interpolated samples, or zero-order-hold samples.

## Interface
- BW, 16, sample width (signed, two's complement) on input and output
- OSR_LOG2, 3, log2 of the upsampling ratio; phase counter width
- DIV_W, 8, width of the output-rate divider setting

- clk_i  in  1  clock, posedge
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- en_i  in  1  enable; low forces the idle state described below
- interp_en_i  in  1  1 = linear interpolation, 0 = zero-order hold
- div_i  in  DIV_W  output strobe period minus one, in clocks
- data_i  in  BW  signed sample from the source; valid combinationally in the data_rd_o cycle
- data_rd_o  out  1  one-cycle read pulse to the source; data_i is captured in the same cycle
- data_o  out  BW  signed output sample, registered
- data_vld_o  out  1  one-cycle pulse, registered; data_o is new in this cycle

## Operation
- Registers and their reset / idle values:
  - div_cnt (DIV_W), phase (OSR_LOG2), x1 (BW, newest sample), delta (BW+1), acc (BW+OSR_LOG2+1): all 0
  - data_o = 0, data_vld_o = 0
- rst_i high or en_i low in a cycle: all registers load 0 on the next edge.
- data_rd_o = 0 whenever rst_i is high or en_i is low.
- tick = en_i & !rst_i & (div_cnt >= div_i).
  - On tick: div_cnt <= 0.
  - Otherwise, when enabled: div_cnt <= div_cnt + 1.
  - Using >= means a mid-run decrease of div_i takes effect without a long wrap.
- data_rd_o = tick & (phase == 0). This is a combinational function of registers and inputs; no extra delay.
- On tick with phase == 0 (load):
  - x1 <= data_i
  - delta <= data_i - x1 (sign-extended to BW+1, exact)
  - acc <= x1 << OSR_LOG2, i.e. the previous newest sample becomes the new base
- On tick with phase != 0: acc <= acc + delta (exact, no overflow possible).
- On every tick: phase <= phase + 1, wrapping modulo 2**OSR_LOG2.
- Output on every tick (data_vld_o <= 1 next edge, else 0):
  - Interpolation mode: data_o <= acc_next >>> OSR_LOG2 (arithmetic shift, floor).
  - Hold mode: data_o <= x1_next.
- Range rule: interpolated values always lie in [min(x0,x1), max(x0,x1)], so truncation to BW bits is lossless. Full-scale swing -32768 -> 32767 must not wrap.
- Interpolation adds a group delay of one input sample period: the first phase after a load outputs the previous sample. Hold mode has no such delay.
- interp_en_i may change at any time and takes effect on the next tick. acc and delta are maintained in both modes.

## Timing
- "Enabled cycle n" counts from the first cycle with en_i = 1 and rst_i = 0, starting at n = 0.
- Ticks fall on enabled cycles k·(div_i+1) + div_i.
  - With div_i = 0, every cycle ticks and data_rd_o asserts in enabled cycle 0.
- data_rd_o asserts on every 2**OSR_LOG2-th tick, starting with the first tick.
- data_vld_o and the new data_o appear one clock after each tick.
- Reset or en_i falling mid-phase: next edge all outputs are 0 and phase = 0. The next enable starts with a load.
- A tick coinciding with rst_i high: no read and no output; reset wins.

## Test plan
Bench parameters: BW = 16, OSR_LOG2 = 2.
- Reset: assert rst_i for 3 clocks with en_i = 1 and data_i = 1234 -> data_o = 0, data_vld_o = 0, data_rd_o = 0 throughout; first data_rd_o appears in enabled cycle 0 after release (div_i = 0).
- Ramp-up interpolation: div_i = 0, interp_en_i = 1, data_i = 1000 constant -> data_rd_o in cycles 0, 4, 8. data_o sequence 0, 250, 500, 750, then 1000 ×4, with data_vld_o high every cycle.
- Negative floor: source steps 0 -> -3 -> data_o 0, -1, -2, -3 (the arithmetic shift floors 0, -0.75, -1.5, -2.25); then x1 = 3 -> delta = 6 -> data_o -3, -2, 0, 1.
- Full scale: source alternates -32768 / 32767 -> data_o stays monotonic within the range on each segment and never wraps; mid-phase values are -16385, -1, 16383 on the rising segment.
- Divider and hold: div_i = 3, interp_en_i = 0 -> data_vld_o every 4 clocks and data_rd_o every 16 clocks; data_o equals the captured sample for all 4 phases. Changing div_i 200 -> 2 mid-count gives a tick on the next cycle.
- Disable mid-phase: drop en_i at phase 2 -> next edge data_o = 0 and phase = 0; re-enable -> data_rd_o on the first tick, base sample 0.

Source files
------------

// File: rtl/audiodac_upsampler.sv
// audiodac_upsampler: paces the delta-sigma modulator with a programmable
// output strobe and fills the gaps between source samples with linear
// interpolation or zero-order hold.
module audiodac_upsampler #(
  parameter int BW       = 16,
  parameter int OSR_LOG2 = 3,
  parameter int DIV_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             interp_en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [BW-1:0]    data_i,
  output logic             data_rd_o,
  output logic [BW-1:0]    data_o,
  output logic             data_vld_o
);

  // acc holds base*2^OSR plus up to (2^OSR-1) deltas; one extra bit covers
  // the full-scale swing without wrapping.
  localparam int AW = BW + OSR_LOG2 + 1;

  logic [DIV_W-1:0]    div_cnt;
  logic [OSR_LOG2-1:0] phase;
  logic [BW-1:0]       x1, x1_next;
  logic [BW:0]         delta, delta_next;
  logic [AW-1:0]       acc, acc_next;
  logic [BW-1:0]       out_next;
  logic                run, tick, load;

  assign run  = en_i & ~rst_i;
  // >= so a mid-count decrease of div_i ticks at once instead of wrapping
  assign tick = run & (div_cnt >= div_i);
  assign load = tick & (phase == '0);
  assign data_rd_o = load;

  // Next-state values for the sample path, shared by both output modes
  always_comb begin
    x1_next    = x1;
    delta_next = delta;
    acc_next   = acc;
    if (load) begin
      x1_next    = data_i;
      delta_next = {data_i[BW-1], data_i} - {x1[BW-1], x1};
      // previous newest sample becomes the base of the new segment
      acc_next   = {{(OSR_LOG2+1){x1[BW-1]}}, x1} << OSR_LOG2;
    end else if (tick) begin
      acc_next   = acc + {{OSR_LOG2{delta[BW]}}, delta};
    end
    // dropping the low OSR_LOG2 bits of a two's complement value is a floor
    out_next = interp_en_i ? acc_next[OSR_LOG2 +: BW] : x1_next;
  end

  // Divider, phase, sample state and registered output; disable clears all
  always_ff @(posedge clk_i) begin
    if (!run) begin
      div_cnt    <= '0;
      phase      <= '0;
      x1         <= '0;
      delta      <= '0;
      acc        <= '0;
      data_o     <= '0;
      data_vld_o <= 1'b0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      x1         <= x1_next;
      delta      <= delta_next;
      acc        <= acc_next;
      data_vld_o <= tick;
      if (tick) begin
        phase  <= phase + 1'b1;
        data_o <= out_next;
      end
    end
  end

endmodule

// File: tb/tb_audiodac_upsampler.sv
// Directed bench for audiodac_upsampler with BW=16, OSR_LOG2=2.
module tb_audiodac_upsampler;

  localparam int BW = 16;
  localparam int OSR_LOG2 = 2;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             en_i = 1'b0;
  logic             interp_en_i = 1'b1;
  logic [DIV_W-1:0] div_i = '0;
  logic [BW-1:0]    data_i = '0;
  logic             data_rd_o;
  logic [BW-1:0]    data_o;
  logic             data_vld_o;

  int n_tests = 0;
  int n_fail  = 0;

  audiodac_upsampler #(.BW(BW), .OSR_LOG2(OSR_LOG2), .DIV_W(DIV_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .interp_en_i (interp_en_i),
    .div_i       (div_i),
    .data_i      (data_i),
    .data_rd_o   (data_rd_o),
    .data_o      (data_o),
    .data_vld_o  (data_vld_o)
  );

  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1 after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    en_i  = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b1; div_i = 0; interp_en_i = 1'b1; data_i = 16'd1234;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (data_rd_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd cyc %0d got %b exp 0", i, data_rd_o); end
      step();
      n_tests++;
      if (data_o !== 16'd0 || data_vld_o !== 1'b0) begin
        n_fail++; $display("FAIL reset_out cyc %0d got %0d/%b exp 0/0", i, $signed(data_o), data_vld_o);
      end
    end
    rst_i = 1'b0;
    #1;
    n_tests++;
    if (data_rd_o !== 1'b1) begin n_fail++; $display("FAIL reset_first_rd got %b exp 1", data_rd_o); end
    step();
  endtask

  task automatic test_ramp();
    logic signed [BW-1:0] exp_o [8] = '{0, 250, 500, 750, 1000, 1000, 1000, 1000};
    do_reset();
    div_i = 0; interp_en_i = 1'b1; data_i = 16'd1000;
    for (int i = 0; i < 9; i++) begin
      #1;
      n_tests++;
      if (data_rd_o !== (i % 4 == 0)) begin n_fail++; $display("FAIL ramp_rd cyc %0d got %b exp %b", i, data_rd_o, (i % 4 == 0)); end
      step();
      if (i < 8) begin
        n_tests++;
        if (data_vld_o !== 1'b1 || $signed(data_o) !== exp_o[i]) begin
          n_fail++; $display("FAIL ramp_out cyc %0d got %0d/%b exp %0d/1", i, $signed(data_o), data_vld_o, exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_neg_floor();
    logic signed [BW-1:0] src [2] = '{-16'sd3, 16'sd3};
    logic signed [BW-1:0] exp_o [8] = '{0, -1, -2, -3, -3, -2, 0, 1};
    do_reset();
    div_i = 0; interp_en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_i = src[i / 4];
      step();
      n_tests++;
      if (data_vld_o !== 1'b1 || $signed(data_o) !== exp_o[i]) begin
        n_fail++; $display("FAIL neg_floor cyc %0d got %0d/%b exp %0d/1", i, $signed(data_o), data_vld_o, exp_o[i]);
      end
    end
  endtask

  task automatic test_full_scale();
    logic signed [BW-1:0] src [3] = '{-16'sd32768, 16'sd32767, -16'sd32768};
    logic signed [BW-1:0] exp_o [12] = '{0, -8192, -16384, -24576,
                                         -32768, -16385, -1, 16383,
                                         32767, 16383, -1, -16385};
    do_reset();
    div_i = 0; interp_en_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      data_i = src[i / 4];
      step();
      n_tests++;
      if ($signed(data_o) !== exp_o[i]) begin
        n_fail++; $display("FAIL full_scale cyc %0d got %0d exp %0d", i, $signed(data_o), exp_o[i]);
      end
    end
  endtask

  task automatic test_div_hold();
    logic signed [BW-1:0] exp_v;
    do_reset();
    div_i = 3; interp_en_i = 1'b0;
    for (int c = 0; c < 32; c++) begin
      data_i = (c < 16) ? 16'd100 : 16'hFF38; // 100 then -200
      #1;
      n_tests++;
      if (data_rd_o !== (c == 3 || c == 19)) begin n_fail++; $display("FAIL hold_rd cyc %0d got %b exp %b", c, data_rd_o, (c == 3 || c == 19)); end
      step();
      n_tests++;
      if (data_vld_o !== (c % 4 == 3)) begin n_fail++; $display("FAIL hold_vld cyc %0d got %b exp %b", c, data_vld_o, (c % 4 == 3)); end
      if (c % 4 == 3) begin
        exp_v = (c < 19) ? 16'sd100 : -16'sd200;
        n_tests++;
        if ($signed(data_o) !== exp_v) begin n_fail++; $display("FAIL hold_out cyc %0d got %0d exp %0d", c, $signed(data_o), exp_v); end
      end
    end
    // large divisor, then shrink it mid-count
    do_reset();
    div_i = 200; data_i = 16'd77;
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if (data_vld_o !== 1'b0) begin n_fail++; $display("FAIL div200_vld cyc %0d got %b exp 0", c, data_vld_o); end
    end
    div_i = 2;
    #1;
    n_tests++;
    if (data_rd_o !== 1'b1) begin n_fail++; $display("FAIL div_shrink_rd got %b exp 1", data_rd_o); end
    step();
    n_tests++;
    if (data_vld_o !== 1'b1 || $signed(data_o) !== 16'sd77) begin
      n_fail++; $display("FAIL div_shrink_out got %0d/%b exp 77/1", $signed(data_o), data_vld_o);
    end
  endtask

  task automatic test_disable();
    logic signed [BW-1:0] exp_o [4] = '{0, 100, 200, 300};
    do_reset();
    div_i = 0; interp_en_i = 1'b1; data_i = 16'd1000;
    step(); step(); // phases 0,1 done; now at phase 2
    en_i = 1'b0;
    #1;
    n_tests++;
    if (data_rd_o !== 1'b0) begin n_fail++; $display("FAIL dis_rd got %b exp 0", data_rd_o); end
    step();
    n_tests++;
    if (data_o !== 16'd0 || data_vld_o !== 1'b0) begin
      n_fail++; $display("FAIL dis_out got %0d/%b exp 0/0", $signed(data_o), data_vld_o);
    end
    en_i = 1'b1; data_i = 16'd400;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (data_rd_o !== (i == 0)) begin n_fail++; $display("FAIL reen_rd cyc %0d got %b exp %b", i, data_rd_o, (i == 0)); end
      step();
      n_tests++;
      if ($signed(data_o) !== exp_o[i]) begin n_fail++; $display("FAIL reen_out cyc %0d got %0d exp %0d", i, $signed(data_o), exp_o[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_neg_floor();
    test_full_scale();
    test_div_hold();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
